fft_out_reorder: RTL and testbench
==================================

Name: fft_out_reorder

Overview:
- Sits at the output of the FFT chip and receives its 34-bit result words.
- Each word is {re[33:17], im[16:0]}, two's complement.
- The FFT core emits each N-point frame in bit-reversed index order. This block captures frames into a ping-pong buffer and re-emits them in natural order over a valid/ready stream to downstream capture logic.
- Continuous streaming is supported: one bank fills while the other drains.

Parameters:
- LOG2N, 4, log2 of frame length (N = 2**LOG2N = 16 points).
- DW, 34, word width (17-bit real + 17-bit imaginary).

Ports:
- clk  input  1  single system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  in_data carries an FFT output word this cycle.
- in_sof  input  1  qualifies in_valid; marks word 0 of a frame.
- in_data  input  DW  FFT output word, bit-reversed order within the frame.
- in_ready  output  1  block can accept a word this cycle.
- out_valid  output  1  out_data holds a valid reordered word.
- out_ready  input  1  downstream accepts out_data this cycle.
- out_data  output  DW  reordered word, natural order.
- out_sof  output  1  out_data is index 0 of a frame.
- out_eof  output  1  out_data is index N-1 of a frame.
- err_ovf  output  1  sticky: in_valid asserted while in_ready=0 (word dropped).
- err_sync  output  1  sticky: frame-framing violation detected.

Behaviour:
- Reset (async, rst=1) drives:
  - Outputs: in_ready=1, out_valid=0, out_data=0, out_sof=0, out_eof=0, err_ovf=0, err_sync=0.
  - State: both bank-full flags=0, wr_bank=0, rd_bank=0, wr_cnt=0, rd_cnt=0, write FSM=W_IDLE, read FSM=R_IDLE.
  - Buffer contents are not reset.
  - Reset mid-frame discards all partial and full frames.
- Storage: 2 banks x N words, register array. Bank select is the MSB of the address.
- in_ready = !full[wr_bank]. Combinational from registers only, no dependency on in_valid.
- Accept condition: in_valid & in_ready.
- in_valid & !in_ready: word dropped, err_ovf set at the next edge; no other state change.
- Write FSM:
  - W_IDLE: words without in_sof are discarded and set err_sync. An accepted word with in_sof is written at address bitrev(0)=0, wr_cnt<=1, go to W_FILL.
  - W_FILL: each accepted word k is written at address bitrev(k), wr_cnt<=wr_cnt+1.
  - in_sof accepted in W_FILL with wr_cnt!=0: set err_sync, abandon the partial frame, treat the word as word 0 of a new frame (wr_cnt<=1).
  - Accepting word N-1: full[wr_bank]<=1, wr_bank toggles, wr_cnt<=0, go to W_IDLE.
- Read FSM:
  - R_IDLE: when full[rd_bank]=1, load word at address 0 of rd_bank into out_data, out_valid<=1, out_sof<=1, rd_cnt<=1, go to R_SEND.
  - R_SEND, on each out_valid & out_ready: load address rd_cnt, out_sof<=0, out_eof<=(rd_cnt==N-1), rd_cnt<=rd_cnt+1.
  - R_SEND, handshake on the out_eof word: full[rd_bank]<=0, rd_bank toggles, rd_cnt<=0.
    - If the other bank is already full, load its word 0 in the same edge (out_valid stays 1, no bubble).
    - Otherwise out_valid<=0 and go to R_IDLE.
  - out_valid=1 & out_ready=0: out_data, out_sof, out_eof hold stable.
- Latency: last word of a frame accepted at edge k (read side idle) -> out_valid=1 with index 0 after edge k+1. Sustained throughput is 1 word/cycle in each direction.
- Same edge, write side sets full[x] while read side clears full[y]: x!=y by construction. Both updates apply.
- Same edge, read side frees a bank and write side targets it: in_ready rises the following cycle, not combinationally in the same cycle.
- err_ovf and err_sync clear only on reset.

Test Plan:
- Single frame: after reset send in_data = 0..15 (in_sof on first), out_ready=1 -> out_data sequence 0,8,4,12,2,10,6,14,1,9,5,13,3,11,7,15. out_sof on the first word, out_eof on the last. out_valid rises one edge after the 16th input; no error flags.
- Back-to-back streaming: 4 consecutive frames with in_valid=1 continuously and out_ready=1 -> in_ready never drops, each output frame correctly reordered, no bubbles between output frames.
- Backpressure: out_ready=0, send 2 frames -> in_ready=0 after the 32nd word. A 33rd word with in_valid=1 sets err_ovf and is dropped. Raise out_ready -> both frames emerge intact and in_ready returns to 1 after the first frame drains.
- Stall hold: toggle out_ready randomly each cycle -> out_data/out_sof/out_eof never change while out_valid=1 & out_ready=0; sequence still matches the single-frame order.
- Sync error: 5 words, then a new in_sof frame of 16 words -> err_sync=1; the output is only the 16-word frame, correctly reordered. Words before any sof also set err_sync and are discarded.
- Async reset mid-frame: assert rst between clock edges during output of word 7 -> all outputs go to reset values immediately. After release, a fresh frame reorders correctly with no stale words emitted.

Source files
------------

// File: rtl/fft_out_reorder_if.sv
// rtl/fft_out_reorder_if.sv - FFT output reorder stream/status interface
interface fft_out_reorder_if #(
  parameter int DW = 34
);
  logic          in_valid;
  logic          in_sof;
  logic [DW-1:0] in_data;
  logic          in_ready;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic          out_sof;
  logic          out_eof;
  logic          err_ovf;
  logic          err_sync;

  // Producer of FFT words / consumer of reordered words
  modport master (
    output in_valid, in_sof, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_sof, out_eof, err_ovf, err_sync
  );

  // The reorder block itself
  modport slave (
    input  in_valid, in_sof, in_data, out_ready,
    output in_ready, out_valid, out_data, out_sof, out_eof, err_ovf, err_sync
  );
endinterface

// File: rtl/fft_out_reorder.sv
// rtl/fft_out_reorder.sv - ping-pong bit-reversed to natural order FFT frame reorder
module fft_out_reorder #(
  parameter int LOG2N = 4,
  parameter int DW    = 34
) (
  input  logic            clk,
  input  logic            rst,
  fft_out_reorder_if.slave bus
);
  localparam int N  = 2 ** LOG2N;
  localparam int AW = LOG2N + 1;

  typedef enum logic { W_IDLE, W_FILL } w_state_t;
  typedef enum logic { R_IDLE, R_SEND } r_state_t;

  // Bank is the address MSB; index within bank in the low bits.
  logic [DW-1:0]    mem [2*N];

  logic [1:0]       full, full_nxt;
  logic             wr_bank, rd_bank, rd_other;
  logic [LOG2N-1:0] wr_cnt, wr_cnt_nxt;
  logic [LOG2N-1:0] rd_cnt, rd_cnt_nxt;
  w_state_t         w_state, w_next;
  r_state_t         r_state, r_next;

  logic             accept;
  logic             wr_en;
  logic [LOG2N-1:0] wr_idx;
  logic             set_full;
  logic             sync_set;

  logic             load;
  logic [AW-1:0]    rd_addr;
  logic             clr_full;
  logic             rd_bank_nxt;
  logic             valid_nxt, sof_nxt, eof_nxt;

  logic [DW-1:0]    out_data_q;
  logic             out_valid_q, out_sof_q, out_eof_q;
  logic             err_ovf_q, err_sync_q;

  function automatic logic [LOG2N-1:0] bitrev(input logic [LOG2N-1:0] a);
    logic [LOG2N-1:0] r;
    for (int i = 0; i < LOG2N; i++) r[i] = a[LOG2N-1-i];
    return r;
  endfunction

  // in_ready depends only on registered state so the producer never sees a combinational path
  assign bus.in_ready = ~full[wr_bank];
  assign accept       = bus.in_valid & bus.in_ready;
  assign rd_other     = ~rd_bank;

  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_sof   = out_sof_q;
  assign bus.out_eof   = out_eof_q;
  assign bus.err_ovf   = err_ovf_q;
  assign bus.err_sync  = err_sync_q;

  // Write side: place accepted words at their bit-reversed slot, detect framing faults
  always_comb begin
    w_next     = w_state;
    wr_en      = 1'b0;
    wr_idx     = '0;
    wr_cnt_nxt = wr_cnt;
    set_full   = 1'b0;
    sync_set   = 1'b0;
    case (w_state)
      W_IDLE: begin
        if (accept) begin
          if (bus.in_sof) begin
            wr_en      = 1'b1;
            wr_cnt_nxt = LOG2N'(1);
            w_next     = W_FILL;
          end else begin
            sync_set = 1'b1;
          end
        end
      end
      W_FILL: begin
        if (accept) begin
          wr_en = 1'b1;
          if (bus.in_sof && wr_cnt != '0) begin
            // Restart: the partial frame is abandoned and this word becomes word 0
            sync_set   = 1'b1;
            wr_cnt_nxt = LOG2N'(1);
          end else begin
            wr_idx = bitrev(wr_cnt);
            if (wr_cnt == LOG2N'(N - 1)) begin
              set_full   = 1'b1;
              wr_cnt_nxt = '0;
              w_next     = W_IDLE;
            end else begin
              wr_cnt_nxt = wr_cnt + 1'b1;
            end
          end
        end
      end
      default: w_next = W_IDLE;
    endcase
  end

  // Read side: walk a full bank in natural order, chaining into the other bank without a bubble
  always_comb begin
    r_next      = r_state;
    load        = 1'b0;
    rd_addr     = '0;
    rd_cnt_nxt  = rd_cnt;
    clr_full    = 1'b0;
    rd_bank_nxt = rd_bank;
    valid_nxt   = out_valid_q;
    sof_nxt     = out_sof_q;
    eof_nxt     = out_eof_q;
    case (r_state)
      R_IDLE: begin
        if (full[rd_bank]) begin
          load       = 1'b1;
          rd_addr    = {rd_bank, {LOG2N{1'b0}}};
          valid_nxt  = 1'b1;
          sof_nxt    = 1'b1;
          eof_nxt    = 1'b0;
          rd_cnt_nxt = LOG2N'(1);
          r_next     = R_SEND;
        end
      end
      R_SEND: begin
        if (out_valid_q && bus.out_ready) begin
          if (out_eof_q) begin
            clr_full    = 1'b1;
            rd_bank_nxt = rd_other;
            if (full[rd_other]) begin
              load       = 1'b1;
              rd_addr    = {rd_other, {LOG2N{1'b0}}};
              sof_nxt    = 1'b1;
              eof_nxt    = 1'b0;
              rd_cnt_nxt = LOG2N'(1);
            end else begin
              valid_nxt  = 1'b0;
              sof_nxt    = 1'b0;
              eof_nxt    = 1'b0;
              rd_cnt_nxt = '0;
              r_next     = R_IDLE;
            end
          end else begin
            load       = 1'b1;
            rd_addr    = {rd_bank, rd_cnt};
            sof_nxt    = 1'b0;
            eof_nxt    = (rd_cnt == LOG2N'(N - 1));
            rd_cnt_nxt = rd_cnt + 1'b1;
          end
        end
      end
      default: r_next = R_IDLE;
    endcase
  end

  // Bank-full flags: writer and reader never touch the same bank in one edge
  always_comb begin
    full_nxt = full;
    if (set_full) full_nxt[wr_bank] = 1'b1;
    if (clr_full) full_nxt[rd_bank] = 1'b0;
  end

  // Frame buffer storage, intentionally not reset
  always_ff @(posedge clk) begin
    if (wr_en) mem[{wr_bank, wr_idx}] <= bus.in_data;
  end

  // Write-side and shared control state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      w_state    <= W_IDLE;
      wr_cnt     <= '0;
      wr_bank    <= 1'b0;
      full       <= '0;
      err_ovf_q  <= 1'b0;
      err_sync_q <= 1'b0;
    end else begin
      w_state <= w_next;
      wr_cnt  <= wr_cnt_nxt;
      full    <= full_nxt;
      if (set_full) wr_bank <= ~wr_bank;
      if (bus.in_valid && !bus.in_ready) err_ovf_q <= 1'b1;
      if (sync_set) err_sync_q <= 1'b1;
    end
  end

  // Read-side state and registered output word
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= R_IDLE;
      rd_cnt      <= '0;
      rd_bank     <= 1'b0;
      out_valid_q <= 1'b0;
      out_sof_q   <= 1'b0;
      out_eof_q   <= 1'b0;
      out_data_q  <= '0;
    end else begin
      r_state     <= r_next;
      rd_cnt      <= rd_cnt_nxt;
      rd_bank     <= rd_bank_nxt;
      out_valid_q <= valid_nxt;
      out_sof_q   <= sof_nxt;
      out_eof_q   <= eof_nxt;
      if (load) out_data_q <= mem[rd_addr];
    end
  end
endmodule

// File: tb/tb_fft_out_reorder.sv
// tb/tb_fft_out_reorder.sv - directed self-checking bench for fft_out_reorder
module tb_fft_out_reorder;
  localparam int DW = 34;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   vectors = 0;
  int   miscompares = 0;

  int order [16] = '{0, 8, 4, 12, 2, 10, 6, 14, 1, 9, 5, 13, 3, 11, 7, 15};

  logic [DW+1:0] outq [$];

  fft_out_reorder_if #(.DW(DW)) bus ();

  fft_out_reorder #(.LOG2N(4), .DW(DW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Record every handshaken output word as {sof, eof, data}
  always @(negedge clk) begin
    if (!rst && bus.out_valid && bus.out_ready)
      outq.push_back({bus.out_sof, bus.out_eof, bus.out_data});
  end

  function automatic logic [DW-1:0] make_word(input int f, input int k);
    logic [16:0] re, im;
    if (f == 0) return DW'(k);
    re = 17'(f * 257 + k * 3 + 1);
    im = 17'(-(f * 64 + k * 5 + 2));
    return {re, im};
  endfunction

  function automatic logic [DW+1:0] exp_out(input int f, input int j);
    return {(j == 0), (j == 15), make_word(f, order[j])};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.in_valid = 1'b0;
    bus.in_sof   = 1'b0;
    bus.in_data  = '0;
  endtask

  task automatic send_word(input logic sof, input logic [DW-1:0] d);
    int w;
    w = 0;
    while (!bus.in_ready && w < 200) begin
      bus.in_valid = 1'b0;
      step();
      w++;
    end
    if (!bus.in_ready) begin
      vectors++;
      miscompares++;
      $display("FAIL send_timeout in_ready=%0b required 1", bus.in_ready);
    end
    bus.in_valid = 1'b1;
    bus.in_sof   = sof;
    bus.in_data  = d;
    step();
  endtask

  task automatic send_frame(input int f, input int nwords, input logic with_sof);
    for (int k = 0; k < nwords; k++) send_word(with_sof && (k == 0), make_word(f, k));
  endtask

  task automatic wait_out(input int n, input int budget);
    int c;
    c = 0;
    while (outq.size() < n && c < budget) begin
      step();
      c++;
    end
    repeat (6) step();
  endtask

  task automatic do_reset();
    idle_inputs();
    bus.out_ready = 1'b0;
    rst = 1'b1;
    step();
    step();
    #2 rst = 1'b0;
    outq.delete();
    step();
  endtask

  task automatic test_reset();
    idle_inputs();
    bus.out_ready = 1'b0;
    rst = 1'b1;
    #3;
    vectors++;
    if ({bus.in_ready, bus.out_valid, bus.out_sof, bus.out_eof, bus.err_ovf, bus.err_sync} !== 6'b100000) begin
      miscompares++;
      $display("FAIL reset_flags got %b required 100000",
               {bus.in_ready, bus.out_valid, bus.out_sof, bus.out_eof, bus.err_ovf, bus.err_sync});
    end
    vectors++;
    if (bus.out_data !== '0) begin
      miscompares++;
      $display("FAIL reset_out_data got %h required 0", bus.out_data);
    end
    do_reset();
  endtask

  task automatic test_single_frame();
    do_reset();
    bus.out_ready = 1'b1;
    send_frame(0, 16, 1'b1);
    idle_inputs();
    vectors++;
    if (bus.out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL single_latency_early out_valid=%b required 0", bus.out_valid);
    end
    step();
    vectors++;
    if ({bus.out_valid, bus.out_sof, bus.out_data} !== {2'b11, 34'd0}) begin
      miscompares++;
      $display("FAIL single_first_word got v%b s%b %h required v1 s1 0", bus.out_valid, bus.out_sof, bus.out_data);
    end
    wait_out(16, 100);
    vectors++;
    if (outq.size() != 16) begin
      miscompares++;
      $display("FAIL single_count got %0d required 16", outq.size());
    end
    for (int j = 0; j < 16; j++) begin
      vectors++;
      if (outq[j] !== exp_out(0, j)) begin
        miscompares++;
        $display("FAIL single_word%0d got %h required %h", j, outq[j], exp_out(0, j));
      end
    end
    vectors++;
    if ({bus.err_ovf, bus.err_sync} !== 2'b00) begin
      miscompares++;
      $display("FAIL single_errors got %b required 00", {bus.err_ovf, bus.err_sync});
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    bus.out_ready = 1'b1;
    for (int f = 0; f < 4; f++) send_frame(10 + f, 16, 1'b1);
    idle_inputs();
    wait_out(64, 300);
    vectors++;
    if (outq.size() != 64) begin
      miscompares++;
      $display("FAIL b2b_count got %0d required 64", outq.size());
    end
    for (int f = 0; f < 4; f++) begin
      for (int j = 0; j < 16; j++) begin
        vectors++;
        if (outq[f*16+j] !== exp_out(10 + f, j)) begin
          miscompares++;
          $display("FAIL b2b_f%0d_w%0d got %h required %h", f, j, outq[f*16+j], exp_out(10 + f, j));
        end
      end
    end
    vectors++;
    if ({bus.err_ovf, bus.err_sync} !== 2'b00) begin
      miscompares++;
      $display("FAIL b2b_errors got %b required 00", {bus.err_ovf, bus.err_sync});
    end
  endtask

  task automatic test_backpressure();
    int c;
    do_reset();
    bus.out_ready = 1'b0;
    send_frame(50, 16, 1'b1);
    send_frame(51, 16, 1'b1);
    idle_inputs();
    vectors++;
    if (bus.in_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL bp_in_ready_full got %b required 0", bus.in_ready);
    end
    bus.in_valid = 1'b1;
    bus.in_data  = make_word(99, 0);
    step();
    idle_inputs();
    vectors++;
    if ({bus.err_ovf, bus.err_sync} !== 2'b10) begin
      miscompares++;
      $display("FAIL bp_err_ovf got ovf%b sync%b required ovf1 sync0", bus.err_ovf, bus.err_sync);
    end
    vectors++;
    if ({bus.out_valid, bus.out_sof, bus.out_data} !== {2'b11, make_word(50, 0)}) begin
      miscompares++;
      $display("FAIL bp_held_first got v%b s%b %h required v1 s1 %h", bus.out_valid, bus.out_sof, bus.out_data, make_word(50, 0));
    end
    bus.out_ready = 1'b1;
    c = 0;
    while (!bus.in_ready && c < 100) begin
      step();
      c++;
    end
    vectors++;
    if (bus.in_ready !== 1'b1 || outq.size() != 16) begin
      miscompares++;
      $display("FAIL bp_ready_return in_ready=%b drained=%0d required in_ready=1 drained=16", bus.in_ready, outq.size());
    end
    wait_out(32, 100);
    vectors++;
    if (outq.size() != 32) begin
      miscompares++;
      $display("FAIL bp_count got %0d required 32", outq.size());
    end
    for (int f = 0; f < 2; f++) begin
      for (int j = 0; j < 16; j++) begin
        vectors++;
        if (outq[f*16+j] !== exp_out(50 + f, j)) begin
          miscompares++;
          $display("FAIL bp_f%0d_w%0d got %h required %h", f, j, outq[f*16+j], exp_out(50 + f, j));
        end
      end
    end
  endtask

  task automatic test_stall_hold();
    logic [DW+1:0] held;
    logic          prev_stall;
    int            c;
    do_reset();
    bus.out_ready = 1'b0;
    send_frame(30, 16, 1'b1);
    idle_inputs();
    prev_stall = 1'b0;
    held = '0;
    c = 0;
    while (outq.size() < 16 && c < 400) begin
      if (prev_stall) begin
        vectors++;
        if ({bus.out_sof, bus.out_eof, bus.out_data} !== held) begin
          miscompares++;
          $display("FAIL stall_hold cyc%0d got %h required %h", c, {bus.out_sof, bus.out_eof, bus.out_data}, held);
        end
      end
      bus.out_ready = (c < 2) ? 1'b0 : 1'($urandom_range(0, 1));
      held = {bus.out_sof, bus.out_eof, bus.out_data};
      prev_stall = bus.out_valid && !bus.out_ready;
      step();
      c++;
    end
    bus.out_ready = 1'b1;
    wait_out(16, 50);
    vectors++;
    if (outq.size() != 16) begin
      miscompares++;
      $display("FAIL stall_count got %0d required 16", outq.size());
    end
    for (int j = 0; j < 16; j++) begin
      vectors++;
      if (outq[j] !== exp_out(30, j)) begin
        miscompares++;
        $display("FAIL stall_word%0d got %h required %h", j, outq[j], exp_out(30, j));
      end
    end
  endtask

  task automatic test_sync_error();
    do_reset();
    bus.out_ready = 1'b1;
    send_frame(40, 5, 1'b1);
    idle_inputs();
    step();
    vectors++;
    if (bus.err_sync !== 1'b0) begin
      miscompares++;
      $display("FAIL sync_partial_early got %b required 0", bus.err_sync);
    end
    send_frame(41, 16, 1'b1);
    idle_inputs();
    wait_out(16, 100);
    vectors++;
    if ({bus.err_sync, bus.err_ovf} !== 2'b10) begin
      miscompares++;
      $display("FAIL sync_restart_flag got sync%b ovf%b required sync1 ovf0", bus.err_sync, bus.err_ovf);
    end
    vectors++;
    if (outq.size() != 16) begin
      miscompares++;
      $display("FAIL sync_restart_count got %0d required 16", outq.size());
    end
    for (int j = 0; j < 16; j++) begin
      vectors++;
      if (outq[j] !== exp_out(41, j)) begin
        miscompares++;
        $display("FAIL sync_restart_w%0d got %h required %h", j, outq[j], exp_out(41, j));
      end
    end

    do_reset();
    bus.out_ready = 1'b1;
    send_frame(42, 3, 1'b0);
    idle_inputs();
    step();
    vectors++;
    if ({bus.err_sync, bus.out_valid} !== 2'b10) begin
      miscompares++;
      $display("FAIL sync_nosof got sync%b valid%b required sync1 valid0", bus.err_sync, bus.out_valid);
    end
    send_frame(43, 16, 1'b1);
    idle_inputs();
    wait_out(16, 100);
    vectors++;
    if (outq.size() != 16) begin
      miscompares++;
      $display("FAIL sync_nosof_count got %0d required 16", outq.size());
    end
    for (int j = 0; j < 16; j++) begin
      vectors++;
      if (outq[j] !== exp_out(43, j)) begin
        miscompares++;
        $display("FAIL sync_nosof_w%0d got %h required %h", j, outq[j], exp_out(43, j));
      end
    end
  endtask

  task automatic test_async_reset();
    int c;
    do_reset();
    bus.out_ready = 1'b1;
    send_frame(20, 16, 1'b1);
    idle_inputs();
    c = 0;
    while (!(bus.out_valid && bus.out_data === make_word(20, order[7])) && c < 100) begin
      step();
      c++;
    end
    vectors++;
    if (bus.out_data !== make_word(20, order[7])) begin
      miscompares++;
      $display("FAIL arst_reach_word7 got %h required %h", bus.out_data, make_word(20, order[7]));
    end
    #2 rst = 1'b1;
    #1;
    vectors++;
    if ({bus.in_ready, bus.out_valid, bus.out_sof, bus.out_eof, bus.err_ovf, bus.err_sync} !== 6'b100000
        || bus.out_data !== '0) begin
      miscompares++;
      $display("FAIL arst_immediate got flags %b data %h required 100000 data 0",
               {bus.in_ready, bus.out_valid, bus.out_sof, bus.out_eof, bus.err_ovf, bus.err_sync}, bus.out_data);
    end
    step();
    step();
    #3 rst = 1'b0;
    outq.delete();
    step();
    send_frame(21, 16, 1'b1);
    idle_inputs();
    wait_out(16, 100);
    vectors++;
    if (outq.size() != 16) begin
      miscompares++;
      $display("FAIL arst_fresh_count got %0d required 16", outq.size());
    end
    for (int j = 0; j < 16; j++) begin
      vectors++;
      if (outq[j] !== exp_out(21, j)) begin
        miscompares++;
        $display("FAIL arst_fresh_w%0d got %h required %h", j, outq[j], exp_out(21, j));
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_back_to_back();
    test_backpressure();
    test_stall_hold();
    test_sync_error();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
